m3gate_monitor: RTL and testbench

Receive-side checker for the six-wire 3-phase gate-drive bus (aHP/aLN, bHP/bLN, cHP/cLN) produced by the motor commutation core. It samples the gate lines and decodes the 6-step commutation state and rotation direction. It measures the step period, tolerates bounded dead-time gaps, and latches a fault code on shoot-through, illegal combinations or out-of-sequence steps. It sits beside the driver in `motoro301_rtl_top`, feeding the LED and UART status paths, and is reused standalone as a bench monitor.

---
 rtl/m3_pkg.sv | 27 ++
 rtl/m3gate_decode.sv | 47 ++++
 rtl/m3gate_monitor.sv | 162 ++++++++++++++++
 tb/tb_m3gate_monitor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/m3_pkg.sv
// Shared definitions for the 3-phase gate-drive bus: fault codes, FSM states,
// gate classes and the step-to-gate pattern table used by driver and monitor.
package m3_pkg;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_SHOOT    = 3'd1;
    localparam logic [2:0] FC_ILLEGAL  = 3'd2;
    localparam logic [2:0] FC_DEADTIME = 3'd3;
    localparam logic [2:0] FC_SKIP     = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DEAD, ST_FAULT} state_t;

    typedef enum logic [2:0] {CLS_OFF, CLS_DEAD, CLS_STEP, CLS_SHOOT, CLS_ILLEGAL} gclass_t;

    // Gate word layout: {cLN, cHP, bLN, bHP, aLN, aHP}; HP lines are active-low.
    localparam logic [5:0] G_OFF = 6'b010101;

    localparam logic [5:0][5:0] STEP_GATE = {
        6'b001101,  // 5: C high, B low
        6'b000111,  // 4: C high, A low
        6'b010011,  // 3: B high, A low
        6'b110001,  // 2: B high, C low
        6'b110100,  // 1: A high, C low
        6'b011100   // 0: A high, B low
    };

endpackage

// File: rtl/m3gate_decode.sv
// Combinational classifier for the registered gate word: class, step index
// and whether that step is the same as, or adjacent to, the current step.
module m3gate_decode
    import m3_pkg::*;
(
    input  logic [5:0] g,
    input  logic [2:0] step_cur,
    output gclass_t    cls,
    output logic [2:0] k,
    output logic       is_same,
    output logic       is_next,
    output logic       is_prev
);

    logic [2:0] hi;
    logic [2:0] lo;
    logic [2:0] next_step;
    logic [2:0] prev_step;

    always_comb begin
        hi  = {!g[4], !g[2], !g[0]};
        lo  = {g[5], g[3], g[1]};
        cls = CLS_OFF;
        k   = 3'd0;
        if (|(hi & lo)) begin
            cls = CLS_SHOOT;
        end else if ($countones(hi) > 1 || $countones(lo) > 1) begin
            cls = CLS_ILLEGAL;
        end else if (hi == 3'b000 && lo == 3'b000) begin
            cls = CLS_OFF;
        end else if (hi == 3'b000 || lo == 3'b000) begin
            cls = CLS_DEAD;
        end else begin
            cls = CLS_STEP;
        end
        for (int i = 0; i < 6; i++) begin
            if (g == STEP_GATE[i]) k = 3'(i);
        end
    end

    assign next_step = (step_cur == 3'd5) ? 3'd0 : step_cur + 3'd1;
    assign prev_step = (step_cur == 3'd0) ? 3'd5 : step_cur - 3'd1;
    assign is_same   = (k == step_cur);
    assign is_next   = (k == next_step);
    assign is_prev   = (k == prev_step);

endmodule

// File: rtl/m3gate_monitor.sv
// Receive-side monitor for the six-wire gate bus: tracks the commutation step,
// direction and step period, and latches the first fault seen.
module m3gate_monitor
    import m3_pkg::*;
#(
    parameter int DEAD_MAX = 16,
    parameter int PW       = 24
) (
    input  logic          clk50mhz,
    input  logic          reset,
    input  logic          aHP,
    input  logic          bHP,
    input  logic          cHP,
    input  logic          aLN,
    input  logic          bLN,
    input  logic          cLN,
    input  logic          faultClr,
    output logic [2:0]    step,
    output logic          stepValid,
    output logic          stepStrobe,
    output logic          dirFwd,
    output logic [PW-1:0] period,
    output logic          periodValid,
    output logic          fault,
    output logic [2:0]    faultCode
);

    localparam int DW = $clog2(DEAD_MAX + 1);

    logic [5:0]    g;
    state_t        state, state_nx;
    gclass_t       cls;
    logic [2:0]    k;
    logic          is_same, is_next, is_prev;
    logic [DW-1:0] dead_cnt, dead_nx;
    logic [PW-1:0] cnt, cnt_nx, period_nx;
    logic          seen, seen_nx;
    logic [2:0]    step_nx, code_nx;
    logic          dir_nx, strobe_nx, pvld_nx;

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (&v) ? v : v + PW'(1);
    endfunction

    m3gate_decode u_decode (
        .g        (g),
        .step_cur (step),
        .cls      (cls),
        .k        (k),
        .is_same  (is_same),
        .is_next  (is_next),
        .is_prev  (is_prev)
    );

    always_comb begin
        state_nx  = state;
        step_nx   = step;
        dir_nx    = dirFwd;
        strobe_nx = 1'b0;
        code_nx   = faultCode;
        dead_nx   = '0;
        cnt_nx    = cnt;
        period_nx = period;
        pvld_nx   = periodValid;
        seen_nx   = seen;
        unique case (state)
            ST_FAULT: begin
                if (faultClr) begin
                    state_nx = ST_IDLE;
                    code_nx  = FC_NONE;
                end
            end
            default: begin
                if (state != ST_IDLE) cnt_nx = sat_inc(cnt);
                case (cls)
                    CLS_SHOOT: begin
                        state_nx = ST_FAULT;
                        code_nx  = FC_SHOOT;
                    end
                    CLS_ILLEGAL: begin
                        state_nx = ST_FAULT;
                        code_nx  = FC_ILLEGAL;
                    end
                    CLS_OFF: state_nx = ST_IDLE;
                    CLS_DEAD: begin
                        // A dead gap is only timed once a step has been seen.
                        if (state != ST_IDLE) begin
                            dead_nx = (state == ST_DEAD) ? dead_cnt + DW'(1) : DW'(1);
                            if (int'(dead_nx) >= DEAD_MAX) begin
                                state_nx = ST_FAULT;
                                code_nx  = FC_DEADTIME;
                            end else begin
                                state_nx = ST_DEAD;
                            end
                        end
                    end
                    CLS_STEP: begin
                        if (state == ST_IDLE) begin
                            state_nx = ST_RUN;
                            step_nx  = k;
                        end else if (is_same) begin
                            state_nx = ST_RUN;
                        end else if (is_next || is_prev) begin
                            state_nx  = ST_RUN;
                            step_nx   = k;
                            dir_nx    = is_next;
                            strobe_nx = 1'b1;
                            period_nx = sat_inc(cnt);
                            cnt_nx    = '0;
                            pvld_nx   = periodValid | seen;
                            seen_nx   = 1'b1;
                        end else begin
                            state_nx = ST_FAULT;
                            code_nx  = FC_SKIP;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
        if (state_nx == ST_IDLE) begin
            cnt_nx  = '0;
            pvld_nx = 1'b0;
            seen_nx = 1'b0;
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk50mhz) begin
        if (reset) begin
            g           <= G_OFF;
            step        <= 3'd0;
            dirFwd      <= 1'b1;
            stepStrobe  <= 1'b0;
            period      <= '0;
            periodValid <= 1'b0;
            faultCode   <= FC_NONE;
            dead_cnt    <= '0;
            cnt         <= '0;
            seen        <= 1'b0;
        end else begin
            g           <= {cLN, cHP, bLN, bHP, aLN, aHP};
            step        <= step_nx;
            dirFwd      <= dir_nx;
            stepStrobe  <= strobe_nx;
            period      <= period_nx;
            periodValid <= pvld_nx;
            faultCode   <= code_nx;
            dead_cnt    <= dead_nx;
            cnt         <= cnt_nx;
            seen        <= seen_nx;
        end
    end

    assign stepValid = (state == ST_RUN);
    assign fault     = (state == ST_FAULT);

endmodule

// File: tb/tb_m3gate_monitor.sv
// Directed bench for m3gate_monitor: step sequences, faults, clear and reset.
module tb_m3gate_monitor;

    logic        clk50mhz = 1'b0;
    logic        reset = 1'b1;
    logic        aHP = 1'b1, bHP = 1'b1, cHP = 1'b1;
    logic        aLN = 1'b0, bLN = 1'b0, cLN = 1'b0;
    logic        faultClr = 1'b0;
    logic [2:0]  step;
    logic        stepValid, stepStrobe, dirFwd;
    logic [23:0] period;
    logic        periodValid, fault;
    logic [2:0]  faultCode;

    int tests_run = 0;
    int tests_failed = 0;
    int strobe_cnt = 0;
    logic [23:0] per_q[$];
    bit          pv_q[$];
    int hi_tab[6] = '{0, 0, 1, 1, 2, 2};
    int lo_tab[6] = '{1, 2, 2, 0, 0, 1};

    m3gate_monitor #(.DEAD_MAX(16), .PW(24)) dut (
        .clk50mhz(clk50mhz), .reset(reset),
        .aHP(aHP), .bHP(bHP), .cHP(cHP), .aLN(aLN), .bLN(bLN), .cLN(cLN),
        .faultClr(faultClr), .step(step), .stepValid(stepValid),
        .stepStrobe(stepStrobe), .dirFwd(dirFwd), .period(period),
        .periodValid(periodValid), .fault(fault), .faultCode(faultCode)
    );

    always #10 clk50mhz = ~clk50mhz;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk50mhz);
            #1;
            if (stepStrobe === 1'b1) begin
                strobe_cnt++;
                per_q.push_back(period);
                pv_q.push_back(periodValid);
            end
        end
    endtask

    // Phase index 0=A, 1=B, 2=C; -1 leaves that side off.
    task automatic drive(input int hi, input int lo);
        aHP = !(hi == 0); bHP = !(hi == 1); cHP = !(hi == 2);
        aLN = (lo == 0);  bLN = (lo == 1);  cLN = (lo == 2);
    endtask

    task automatic drive_step(input int k);
        drive(hi_tab[k], lo_tab[k]);
    endtask

    task automatic pulse_clear();
        faultClr = 1'b1;
        tick(1);
        faultClr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(-1, -1);
        tick(2);
        reset = 1'b0;
        tests_run++; if (step !== 3'd0) begin tests_failed++; $display("FAIL rst_step: got %0d expected 0", step); end
        tests_run++; if (stepValid !== 1'b0) begin tests_failed++; $display("FAIL rst_stepValid: got %0b expected 0", stepValid); end
        tests_run++; if (dirFwd !== 1'b1) begin tests_failed++; $display("FAIL rst_dirFwd: got %0b expected 1", dirFwd); end
        tests_run++; if (period !== 24'd0) begin tests_failed++; $display("FAIL rst_period: got %0d expected 0", period); end
        tests_run++; if (fault !== 1'b0 || faultCode !== 3'd0) begin tests_failed++; $display("FAIL rst_fault: got %0b/%0d expected 0/0", fault, faultCode); end
        tick(100);
        tests_run++; if (stepValid !== 1'b0 || stepStrobe !== 1'b0 || periodValid !== 1'b0) begin tests_failed++; $display("FAIL off_idle: got valid=%0b strobe=%0b pvld=%0b expected 0/0/0", stepValid, stepStrobe, periodValid); end
        tests_run++; if (step !== 3'd0 || dirFwd !== 1'b1 || fault !== 1'b0) begin tests_failed++; $display("FAIL off_state: got step=%0d dir=%0b fault=%0b expected 0/1/0", step, dirFwd, fault); end
    endtask

    task automatic test_forward();
        int prev;
        strobe_cnt = 0; per_q.delete(); pv_q.delete();
        drive_step(0);
        tick(1000);
        prev = 0;
        for (int j = 1; j <= 6; j++) begin
            drive(hi_tab[prev], -1);
            tick(4);
            drive_step(j % 6);
            tick(1000);
            prev = j % 6;
        end
        tests_run++; if (strobe_cnt !== 6) begin tests_failed++; $display("FAIL fwd_strobes: got %0d expected 6", strobe_cnt); end
        for (int i = 0; i < per_q.size(); i++) begin
            tests_run++; if (per_q[i] !== 24'd1004) begin tests_failed++; $display("FAIL fwd_period%0d: got %0d expected 1004", i, per_q[i]); end
            tests_run++; if (pv_q[i] !== (i > 0)) begin tests_failed++; $display("FAIL fwd_pvld%0d: got %0b expected %0b", i, pv_q[i], (i > 0)); end
        end
        tests_run++; if (dirFwd !== 1'b1 || step !== 3'd0) begin tests_failed++; $display("FAIL fwd_end: got dir=%0b step=%0d expected 1/0", dirFwd, step); end
        tests_run++; if (fault !== 1'b0 || periodValid !== 1'b1 || stepValid !== 1'b1) begin tests_failed++; $display("FAIL fwd_flags: got fault=%0b pvld=%0b valid=%0b expected 0/1/1", fault, periodValid, stepValid); end
    endtask

    task automatic test_reverse();
        drive(-1, -1);
        tick(3);
        strobe_cnt = 0;
        drive_step(2); tick(5);
        drive_step(1); tick(5);
        drive_step(0); tick(5);
        drive_step(5); tick(5);
        tests_run++; if (strobe_cnt !== 3) begin tests_failed++; $display("FAIL rev_strobes: got %0d expected 3", strobe_cnt); end
        tests_run++; if (dirFwd !== 1'b0 || step !== 3'd5) begin tests_failed++; $display("FAIL rev_wrap: got dir=%0b step=%0d expected 0/5", dirFwd, step); end
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL rev_fault: got %0b expected 0", fault); end
        drive_step(0); tick(5);
        tests_run++; if (dirFwd !== 1'b1 || step !== 3'd0) begin tests_failed++; $display("FAIL rev_flip: got dir=%0b step=%0d expected 1/0", dirFwd, step); end
        pulse_clear();
        tick(1);
        tests_run++; if (stepValid !== 1'b1 || step !== 3'd0 || fault !== 1'b0) begin tests_failed++; $display("FAIL clr_ignored: got valid=%0b step=%0d fault=%0b expected 1/0/0", stepValid, step, fault); end
    endtask

    task automatic test_shoot();
        aLN = 1'b1;
        tick(1);
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL shoot_lat: got %0b expected 0", fault); end
        tick(1);
        tests_run++; if (fault !== 1'b1 || faultCode !== 3'd1) begin tests_failed++; $display("FAIL shoot_code: got %0b/%0d expected 1/1", fault, faultCode); end
        tests_run++; if (stepStrobe !== 1'b0) begin tests_failed++; $display("FAIL shoot_strobe: got %0b expected 0", stepStrobe); end
        drive(-1, -1); aHP = 1'b0; bHP = 1'b0;
        tick(3);
        tests_run++; if (faultCode !== 3'd1) begin tests_failed++; $display("FAIL shoot_sticky: got %0d expected 1", faultCode); end
        drive(0, 0);
        pulse_clear();
        tests_run++; if (fault !== 1'b0 || faultCode !== 3'd0) begin tests_failed++; $display("FAIL clr_wins: got %0b/%0d expected 0/0", fault, faultCode); end
        tick(1);
        tests_run++; if (fault !== 1'b1 || faultCode !== 3'd1) begin tests_failed++; $display("FAIL clr_reeval: got %0b/%0d expected 1/1", fault, faultCode); end
        drive(-1, -1);
        tick(2);
        pulse_clear();
        tests_run++; if (fault !== 1'b0 || faultCode !== 3'd0 || stepValid !== 1'b0) begin tests_failed++; $display("FAIL shoot_clr: got fault=%0b code=%0d valid=%0b expected 0/0/0", fault, faultCode, stepValid); end
    endtask

    task automatic test_skip();
        drive_step(0); tick(5);
        drive_step(3);
        tick(1);
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL skip_lat: got %0b expected 0", fault); end
        tick(1);
        tests_run++; if (fault !== 1'b1 || faultCode !== 3'd4) begin tests_failed++; $display("FAIL skip_code: got %0b/%0d expected 1/4", fault, faultCode); end
        tests_run++; if (stepStrobe !== 1'b0 || step !== 3'd0) begin tests_failed++; $display("FAIL skip_step: got strobe=%0b step=%0d expected 0/0", stepStrobe, step); end
        drive(-1, -1); tick(2);
        pulse_clear();
        tests_run++; if (faultCode !== 3'd0) begin tests_failed++; $display("FAIL skip_clr: got %0d expected 0", faultCode); end
    endtask

    task automatic test_deadtime();
        drive_step(0); tick(5);
        drive(0, -1);
        tick(16);
        tests_run++; if (fault !== 1'b0 || stepValid !== 1'b0) begin tests_failed++; $display("FAIL dead_15: got fault=%0b valid=%0b expected 0/0", fault, stepValid); end
        tick(1);
        tests_run++; if (fault !== 1'b1 || faultCode !== 3'd3) begin tests_failed++; $display("FAIL dead_16: got %0b/%0d expected 1/3", fault, faultCode); end
        drive(-1, -1); tick(2);
        pulse_clear();
        tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL dead_clr: got %0b expected 0", fault); end
    endtask

    task automatic test_midrun_reset();
        drive(-1, -1); tick(2);
        drive_step(2); tick(5);
        drive_step(1); tick(502);
        tests_run++; if (step !== 3'd1 || dirFwd !== 1'b0 || period !== 24'd5) begin tests_failed++; $display("FAIL pre_rst: got step=%0d dir=%0b period=%0d expected 1/0/5", step, dirFwd, period); end
        reset = 1'b1;
        tick(1);
        tests_run++; if (step !== 3'd0 || dirFwd !== 1'b1 || period !== 24'd0 || stepValid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst: got step=%0d dir=%0b period=%0d valid=%0b expected 0/1/0/0", step, dirFwd, period, stepValid); end
        tests_run++; if (periodValid !== 1'b0 || fault !== 1'b0 || faultCode !== 3'd0 || stepStrobe !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_flags: got pvld=%0b fault=%0b code=%0d strobe=%0b expected 0/0/0/0", periodValid, fault, faultCode, stepStrobe); end
        reset = 1'b0;
        tick(1);
        tests_run++; if (stepValid !== 1'b0) begin tests_failed++; $display("FAIL rst_gclear: got %0b expected 0", stepValid); end
        tick(1);
        tests_run++; if (stepValid !== 1'b1 || step !== 3'd1 || stepStrobe !== 1'b0) begin tests_failed++; $display("FAIL reenter: got valid=%0b step=%0d strobe=%0b expected 1/1/0", stepValid, step, stepStrobe); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_reverse();
        test_shoot();
        test_skip();
        test_deadtime();
        test_midrun_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
